cmd_arbiter_frontend: RTL and testbench
=======================================

Name: cmd_arbiter_frontend

Overview:
- Merges 32-bit command words from N_REQ independent requesters into the single command stream feeding the frontend reset/command controller.
- Normal words are arbitrated round-robin.
- The reset code word (RST_CODE) preempts all normal traffic.
- After a reset word is accepted, normal traffic is held off for HOLDOFF cycles so nothing reaches modules still in reset.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- RST_CODE, 32'hF000_0000, command word that triggers a frontend reset
- HOLDOFF, 32, cycles after accepting a reset word during which normal words are blocked (≥1)
- IW, $clog2(N_REQ), width of the grant index

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-low reset
- req_data  in  N_REQ*32  requester words; requester i uses bits [32i+31:32i]
- req_valid  in  N_REQ  requester i has a word
- req_ready  out  N_REQ  word from requester i accepted this cycle (one-hot or zero)
- data  out  32  registered output word
- valid  out  1  output word valid
- ready  in  1  downstream accepts the output word
- grant_idx  out  IW  requester index of the word currently in `data`
- busy  out  1  holdoff active (HOLD state)

Behaviour:
- Reset (rst=0, async): data=0, valid=0, grant_idx=0, busy=0, rr_ptr=0, holdoff counter=0, state=RUN. req_ready is combinational and is 0 while in reset.
- Output stage is one register, no skid buffer.
- can_load = ~valid | (valid & ready).
- Per cycle, candidate selection:
  - rst_cand = lowest index i with req_valid[i] and word==RST_CODE.
  - norm_cand = first i with req_valid[i] and word!=RST_CODE, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
- Accept rule (at most one accept per cycle):
  - If can_load and rst_cand exists: accept rst_cand, in either state.
  - Else if can_load, state==RUN and norm_cand exists: accept norm_cand.
  - Else accept nothing.
- req_ready[i] = 1 only for the accepted index, in the same cycle (combinational from req_valid, data and state). The requester must hold its word until it sees req_ready.
- On accept, the next edge loads data and grant_idx from the accepted requester and sets valid=1. Latency from accept to valid is 1 cycle.
- valid clears on ready&valid unless a new word is loaded the same cycle; back-to-back throughput is 1 word/cycle.
- rr_ptr:
  - On a normal accept from index k: rr_ptr <= (k+1) mod N_REQ.
  - Unchanged on a reset accept.
  - Wraps from N_REQ-1 to 0.
- FSM:
  - RUN: a reset accept goes to HOLD with cnt <= HOLDOFF.
  - HOLD: cnt decrements each cycle; at cnt==1 with no new reset accept, next state is RUN and cnt becomes 0.
  - HOLD: a reset accept reloads cnt=HOLDOFF and stays in HOLD.
  - busy = (state==HOLD).
  - Normal words are never accepted in HOLD; they stall, with no loss and no reordering within a requester.
- Holdoff timing: a reset word accepted at cycle t blocks normal accepts for cycles t+1 … t+HOLDOFF. The first possible normal accept is cycle t+HOLDOFF+1.
- Simultaneous events:
  - Reset and normal candidates in the same cycle: the reset wins; the normal requester's req_ready stays 0.
  - Multiple reset candidates: lowest index wins; the other is accepted next eligible cycle, reloading holdoff.
  - Output full and ready=0: no accepts at all, including resets; nothing is dropped.
- Reset asserted mid-operation: all state clears immediately, including a pending output word and the holdoff; words in flight at requesters are not acknowledged.
- Arithmetic: the holdoff counter is $clog2(HOLDOFF+1) bits wide and never underflows. Round-robin search uses modulo-N_REQ index arithmetic for non-power-of-2 N_REQ.

Test Plan:
- Round-robin: all 4 requesters hold normal words 0x1,0x2,0x3,0x4, ready=1 → output order 0x1,0x2,0x3,0x4 over 4 consecutive cycles, grant_idx 0,1,2,3, rr_ptr returns to 0.
- Reset preemption: req0=0x0000_00AA and req2=0xF000_0000 asserted together → req2 accepted first; req0 stalled until 32 cycles after the reset accept, then 0x0000_00AA output; busy high for exactly 32 cycles.
- Reset during holdoff: second RST_CODE from req1 arrives 10 cycles into HOLD → accepted immediately, busy extended to 32 cycles after the second accept, rr_ptr unchanged throughout.
- Backpressure: ready=0 for 5 cycles with valid=1 and req1 pending → data stable, req_ready all 0; ready=1 → old word consumed and req1 loaded in the same cycle.
- Wrap/fairness with N_REQ=3: only req2 and req0 continuously valid → grants alternate 2,0,2,0; no starvation.
- Async reset: drop rst low mid-transfer with valid=1 and HOLD active → valid, busy, data, grant_idx go 0 without a clock edge; after release the first grant goes to req0.

Source files
------------

// File: rtl/cmd_arbiter_frontend.sv
// Merges requester command words into one registered stream. Reset-code words
// preempt normal traffic and open a holdoff window that blocks normal words.
module cmd_arbiter_frontend #(
    parameter int          N_REQ    = 4,
    parameter logic [31:0] RST_CODE = 32'hF000_0000,
    parameter int          HOLDOFF  = 32,
    parameter int          IW       = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ*32-1:0] req_data,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    output logic [31:0]         data,
    output logic                valid,
    input  logic                ready,
    output logic [IW-1:0]       grant_idx,
    output logic                busy
);
    localparam int CW = $clog2(HOLDOFF + 1);

    typedef enum logic {RUN, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] grant_q, grant_d;

    logic [N_REQ-1:0] is_rst, is_norm;
    logic             rst_found, norm_found;
    logic [IW-1:0]    rst_idx, norm_idx;
    logic             can_load, acc, acc_rst;
    logic [IW-1:0]    acc_idx;
    logic [31:0]      acc_word;

    for (genvar g = 0; g < N_REQ; g++) begin : g_cls
        assign is_rst[g]    = req_valid[g] && (req_data[g*32 +: 32] == RST_CODE);
        assign is_norm[g]   = req_valid[g] && (req_data[g*32 +: 32] != RST_CODE);
        assign req_ready[g] = acc && (acc_idx == IW'(g));
    end

    // Reset candidates: lowest index. Normal candidates: first hit from rr_ptr onward.
    always_comb begin
        int j;
        j          = 0;
        rst_found  = 1'b0;
        rst_idx    = '0;
        norm_found = 1'b0;
        norm_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (is_rst[i]) begin
                rst_found = 1'b1;
                rst_idx   = IW'(i);
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr_q) + k) % N_REQ;
            if (is_norm[j]) begin
                norm_found = 1'b1;
                norm_idx   = IW'(j);
            end
        end
    end

    assign can_load = !valid_q || ready;

    // rst gating keeps req_ready low while the block is held in reset.
    always_comb begin
        acc     = 1'b0;
        acc_rst = 1'b0;
        acc_idx = '0;
        if (rst && can_load) begin
            if (rst_found) begin
                acc     = 1'b1;
                acc_rst = 1'b1;
                acc_idx = rst_idx;
            end else if (state_q == RUN && norm_found) begin
                acc     = 1'b1;
                acc_idx = norm_idx;
            end
        end
    end

    always_comb begin
        acc_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_idx == IW'(i)) acc_word = req_data[i*32 +: 32];
        end
    end

    always_comb begin
        data_d   = data_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (acc) begin
            data_d  = acc_word;
            grant_d = acc_idx;
            valid_d = 1'b1;
        end else if (ready) begin
            valid_d = 1'b0;
        end
        if (acc && !acc_rst) begin
            rr_ptr_d = (acc_idx == IW'(N_REQ - 1)) ? '0 : acc_idx + IW'(1);
        end
        if (acc_rst) begin
            state_d = HOLD;
            cnt_d   = CW'(HOLDOFF);
        end else if (state_q == HOLD) begin
            if (cnt_q <= CW'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_cmd_arbiter_frontend.sv
// Scoreboard bench for cmd_arbiter_frontend: directed scenarios plus random
// traffic, checked against a cycle-level model of the arbitration rules.
module tb_cmd_arbiter_frontend;
    localparam int          N  = 4;
    localparam logic [31:0] RC = 32'hF000_0000;
    localparam int          HO = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_valid, req_ready;
    logic [31:0]     data;
    logic            valid, ready, busy;
    logic [1:0]      grant_idx;

    cmd_arbiter_frontend #(.N_REQ(N), .RST_CODE(RC), .HOLDOFF(HO)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .data(data), .valid(valid), .ready(ready),
        .grant_idx(grant_idx), .busy(busy)
    );

    // Three-requester instance for the non-power-of-2 wrap case.
    logic [95:0] d3;
    logic [2:0]  v3, r3;
    logic [31:0] o3;
    logic        val3, rdy3, busy3;
    logic [1:0]  g3;

    cmd_arbiter_frontend #(.N_REQ(3), .RST_CODE(RC), .HOLDOFF(HO)) u3 (
        .clk(clk), .rst(rst), .req_data(d3), .req_valid(v3), .req_ready(r3),
        .data(o3), .valid(val3), .ready(rdy3), .grant_idx(g3), .busy(busy3)
    );

    typedef struct {
        logic [31:0] w;
        int          idx;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0, n_err = 0;
    logic [31:0] cur_w[N];
    bit          cur_v[N];
    bit          rdy_drv;
    bit          m_valid;
    int          m_rr, m_hold;
    int          busy_cnt;
    logic [N-1:0] last_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive requesters, predict this cycle's accept, advance the model.
    task automatic step();
        logic [31:0] er;
        int          acc;
        bit          is_r;
        @(negedge clk);
        ready = rdy_drv;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = cur_v[i];
            req_data[i*32 +: 32] = cur_w[i];
        end
        #1;
        acc  = -1;
        is_r = 1'b0;
        if (!m_valid || rdy_drv) begin
            for (int i = N - 1; i >= 0; i--)
                if (cur_v[i] && cur_w[i] == RC) acc = i;
            is_r = (acc >= 0);
            if (!is_r && m_hold == 0)
                for (int k = N - 1; k >= 0; k--)
                    if (cur_v[(m_rr + k) % N] && cur_w[(m_rr + k) % N] != RC) acc = (m_rr + k) % N;
        end
        er = '0;
        if (acc >= 0) er[acc] = 1'b1;
        chk("req_ready", 32'(req_ready), er);
        chk("busy", 32'(busy), 32'(m_hold > 0));
        chk("valid", 32'(valid), 32'(m_valid));
        if (busy) busy_cnt++;
        last_rdy = req_ready;
        if (acc >= 0) begin
            sb.push_back('{w: cur_w[acc], idx: acc});
            cur_v[acc] = 1'b0;
        end
        m_valid = (acc >= 0) || (m_valid && !rdy_drv);
        if (is_r) m_hold = HO;
        else if (m_hold > 0) m_hold--;
        if (acc >= 0 && !is_r) m_rr = (acc + 1) % N;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
    endtask

    // Output monitor: every handshake must match the oldest predicted word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && valid && ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: data %0h with nothing expected", data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", data, e.w);
                    chk("out_idx", 32'(grant_idx), 32'(e.idx));
                end
            end
        end
    end

    initial begin
        int acc0;
        ready     = 1'b0;
        req_valid = '1;
        req_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        d3        = {32'h33, 32'h22, 32'h11};
        v3        = '0;
        rdy3      = 1'b1;
        rdy_drv   = 1'b0;
        m_valid   = 1'b0;
        m_rr      = 0;
        m_hold    = 0;
        busy_cnt  = 0;
        clear_reqs();
        #12;
        chk("rst_data", data, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_grant", 32'(grant_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // N_REQ=3: req0 and req2 always valid -> grants alternate from rr_ptr=0
        v3 = 3'b101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("wrap_grant", 32'(g3), (k % 2) ? 32'd2 : 32'd0);
            chk("wrap_data", o3, (k % 2) ? 32'h33 : 32'h11);
            chk("wrap_valid", 32'(val3), 32'h1);
        end
        v3 = '0;

        // Round-robin over four normal words
        for (int i = 0; i < N; i++) begin
            cur_w[i] = 32'(i + 1);
            cur_v[i] = 1'b1;
        end
        rdy_drv = 1'b1;
        for (int k = 0; k < N; k++) begin
            step();
            chk("rr_order", 32'(last_rdy), 32'(1 << k));
        end
        cur_w[0] = 32'h10; cur_v[0] = 1'b1;
        cur_w[1] = 32'h11; cur_v[1] = 1'b1;
        step();
        chk("rr_wrap", 32'(last_rdy), 32'h1);
        repeat (3) step();

        // Reset preemption: req2 reset word beats req0 normal word
        cur_w[0] = 32'hAA; cur_v[0] = 1'b1;
        cur_w[2] = RC;     cur_v[2] = 1'b1;
        busy_cnt = 0;
        acc0     = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 0) chk("pre_first", 32'(last_rdy), 32'h4);
            if (last_rdy[0] && acc0 < 0) acc0 = k;
        end
        chk("pre_release", acc0, 32'd33);
        chk("pre_busy", busy_cnt, 32'd32);

        // Second reset word 10 cycles into the holdoff extends it
        cur_w[2] = RC; cur_v[2] = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 10) begin
                cur_w[1] = RC;
                cur_v[1] = 1'b1;
            end
            step();
            if (k == 10) chk("hold_reacc", 32'(last_rdy), 32'h2);
        end
        chk("hold_busy", busy_cnt, 32'd42);
        for (int i = 0; i < N; i++) begin
            cur_w[i] = 32'h100 + 32'(i);
            cur_v[i] = 1'b1;
        end
        step();
        chk("hold_rr", 32'(last_rdy), 32'h2);
        repeat (5) step();

        // Backpressure: output full, downstream stalled
        clear_reqs();
        cur_w[0] = 32'h1234; cur_v[0] = 1'b1;
        step();
        rdy_drv  = 1'b0;
        cur_w[1] = 32'h5678; cur_v[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_data", data, 32'h1234);
            chk("bp_stall", 32'(req_ready), 32'h0);
        end
        rdy_drv = 1'b1;
        step();
        chk("bp_load", 32'(last_rdy), 32'h2);
        step();
        chk("bp_next", data, 32'h5678);

        // Async reset with a held word and holdoff active
        rdy_drv  = 1'b0;
        cur_w[3] = RC;    cur_v[3] = 1'b1;
        cur_w[0] = 32'h77; cur_v[0] = 1'b1;
        repeat (3) step();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_data", data, 32'h0);
        chk("arst_grant", 32'(grant_idx), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        m_valid   = 1'b0;
        m_hold    = 0;
        m_rr      = 0;
        sb.delete();
        @(negedge clk);
        rst      = 1'b1;
        cur_w[1] = 32'h88; cur_v[1] = 1'b1;
        cur_w[2] = 32'h99; cur_v[2] = 1'b1;
        rdy_drv  = 1'b1;
        step();
        chk("post_rst_grant", 32'(last_rdy), 32'h1);

        // Random traffic with occasional reset words and random backpressure
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!cur_v[i] && $urandom_range(1, 0) == 1) begin
                    cur_v[i] = 1'b1;
                    cur_w[i] = ($urandom_range(63, 0) == 0) ? RC : $urandom;
                end
            end
            rdy_drv = ($urandom_range(3, 0) != 0);
            step();
        end

        // Drain: no new words, downstream always ready
        rdy_drv = 1'b1;
        repeat (200) step();
        for (int i = 0; i < N; i++) chk("drain_req", 32'(cur_v[i]), 32'h0);
        chk("drain_sb", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
